// File: rtl/xtop_calc_core.sv
// xtop_calc_core: button-driven calculator core. Two synchronized push-buttons
// start short pc-sequenced programs that move operands and compute sum,
// negation and product through a single-write-port register file. r2[15:0]
// is shown in hex on a multiplexed 4-digit 7-segment display.

// Register file: one write port, two combinational read ports and a fixed
// tap of r2's low half for the display.
module xtop_calc_regf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    output logic [15:0]       disp_data
);
    logic [DATA_W-1:0] regf [0:(1<<ADDR_W)-1];

    // All registers clear on reset; a single write per cycle otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < (1<<ADDR_W); i++) begin
                regf[i] <= '0;
            end
        end else if (we) begin
            regf[waddr] <= wdata;
        end
    end

    assign ra_data   = regf[ra_addr];
    assign rb_data   = regf[rb_addr];
    assign disp_data = regf[2][15:0];
endmodule

module xtop_calc_core #(
    parameter int DATA_W      = 32,
    parameter int REGF_ADDR_W = 4,
    parameter int REFRESH_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Btn3,
    input  logic       Btn2,
    input  logic [7:0] Sw,
    output logic       trap,
    output logic [7:0] Disp,
    output logic [3:0] Disp_sel
);
    typedef enum logic [2:0] {
        PC_IDLE  = 3'd0,
        PC_ADD   = 3'd1,
        PC_NEG   = 3'd2,
        PC_MUL   = 3'd3,
        PC_SHIFT = 3'd4,
        PC_LOAD  = 3'd5
    } pc_t;

    pc_t                   pc;
    logic                  data_we;
    logic [REGF_ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic [DATA_W-1:0]     r0_val;
    logic [DATA_W-1:0]     r1_val;
    logic [15:0]           disp_data;

    // Index 0 = Btn2 (execute), index 1 = Btn3 (enter).
    logic [1:0] btn_raw;
    logic [1:0] btn_edge;
    assign btn_raw = {Btn3, Btn2};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic sync1_reg;
            logic sync2_reg;
            logic prev_reg;
            logic edge_reg;

            // Two-flop synchronizer followed by a registered rising-edge detector.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    prev_reg  <= 1'b0;
                    edge_reg  <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                    edge_reg  <= sync2_reg & ~prev_reg;
                end
            end

            assign btn_edge[gi] = edge_reg;
        end
    endgenerate

    logic exec_edge;
    logic enter_edge;
    assign exec_edge  = btn_edge[0];
    assign enter_edge = btn_edge[1];

    // Sequencer: edges are only looked at in IDLE; both at once is a trap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= PC_IDLE;
            trap <= 1'b0;
        end else begin
            case (pc)
                PC_IDLE: begin
                    if (exec_edge && enter_edge) begin
                        trap <= 1'b1;
                    end else if (enter_edge) begin
                        pc <= PC_SHIFT;
                    end else if (exec_edge) begin
                        pc <= PC_ADD;
                    end
                end
                PC_ADD:   pc <= PC_NEG;
                PC_NEG:   pc <= PC_MUL;
                PC_MUL:   pc <= PC_IDLE;
                PC_SHIFT: pc <= PC_LOAD;
                PC_LOAD:  pc <= PC_IDLE;
                default:  pc <= PC_IDLE;
            endcase
        end
    end

    // Write-port mux: each active pc value owns exactly one register write.
    // The product keeps only the low DATA_W bits, which are identical for
    // signed and unsigned multiplication.
    always_comb begin
        data_we    = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        case (pc)
            PC_ADD: begin
                data_we    = 1'b1;
                data_addr  = REGF_ADDR_W'(2);
                data_wdata = r1_val + r0_val;
            end
            PC_NEG: begin
                data_we    = 1'b1;
                data_addr  = REGF_ADDR_W'(3);
                data_wdata = '0 - r0_val;
            end
            PC_MUL: begin
                data_we    = 1'b1;
                data_addr  = REGF_ADDR_W'(4);
                data_wdata = r1_val * r0_val;
            end
            PC_SHIFT: begin
                data_we    = 1'b1;
                data_addr  = REGF_ADDR_W'(1);
                data_wdata = r0_val;
            end
            PC_LOAD: begin
                data_we    = 1'b1;
                data_addr  = REGF_ADDR_W'(0);
                data_wdata = {{(DATA_W-8){Sw[7]}}, Sw};
            end
            default: begin
                data_we    = 1'b0;
            end
        endcase
    end

    xtop_calc_regf #(
        .DATA_W (DATA_W),
        .ADDR_W (REGF_ADDR_W)
    ) regf (
        .clk       (clk),
        .rst       (rst),
        .we        (data_we),
        .waddr     (data_addr),
        .wdata     (data_wdata),
        .ra_addr   (REGF_ADDR_W'(0)),
        .ra_data   (r0_val),
        .rb_addr   (REGF_ADDR_W'(1)),
        .rb_data   (r1_val),
        .disp_data (disp_data)
    );

    // Display: the top two refresh-counter bits pick the digit.
    logic [REFRESH_W+1:0] refresh_cnt_reg;
    logic [1:0]           digit_sel;
    logic [3:0]           nibble;
    logic [7:0]           seg_next;

    assign digit_sel = refresh_cnt_reg[REFRESH_W+1 -: 2];
    assign nibble    = disp_data[{digit_sel, 2'b00} +: 4];

    // Active-low hex font with the decimal point held off.
    always_comb begin
        seg_next = 8'hFF;
        case (nibble)
            4'h0: seg_next = 8'hC0;
            4'h1: seg_next = 8'hF9;
            4'h2: seg_next = 8'hA4;
            4'h3: seg_next = 8'hB0;
            4'h4: seg_next = 8'h99;
            4'h5: seg_next = 8'h92;
            4'h6: seg_next = 8'h82;
            4'h7: seg_next = 8'hF8;
            4'h8: seg_next = 8'h80;
            4'h9: seg_next = 8'h90;
            4'hA: seg_next = 8'h88;
            4'hB: seg_next = 8'h83;
            4'hC: seg_next = 8'hC6;
            4'hD: seg_next = 8'hA1;
            4'hE: seg_next = 8'h86;
            4'hF: seg_next = 8'h8E;
            default: seg_next = 8'hFF;
        endcase
    end

    // Free-running refresh counter and registered segment/select outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt_reg <= '0;
            Disp_sel        <= 4'b1110;
            Disp            <= 8'hC0;
        end else begin
            refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
            Disp_sel        <= ~(4'b0001 << digit_sel);
            Disp            <= seg_next;
        end
    end
endmodule

// File: tb/tb_xtop_calc_core.sv
// Directed bench for xtop_calc_core: stimulus pushes the expected register
// writes into a queue, and a monitor pops and compares each write the DUT makes.
module tb_xtop_calc_core;
    logic       clk = 1'b0;
    logic       rst;
    logic       Btn3;
    logic       Btn2;
    logic [7:0] Sw;
    logic       trap;
    logic [7:0] Disp;
    logic [3:0] Disp_sel;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    xtop_calc_core dut (
        .clk      (clk),
        .rst      (rst),
        .Btn3     (Btn3),
        .Btn2     (Btn2),
        .Sw       (Sw),
        .trap     (trap),
        .Disp     (Disp),
        .Disp_sel (Disp_sel)
    );

    always #5 clk = ~clk;

    // Monitor: every committed write must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && dut.data_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got r%0d <= %h required no write",
                         dut.data_addr, dut.data_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (dut.data_addr !== mon_e.addr || dut.data_wdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL write got r%0d <= %h required r%0d <= %h",
                             dut.data_addr, dut.data_wdata, mon_e.addr, mon_e.data);
                end else begin
                    $display("write r%0d <= %h", dut.data_addr, dut.data_wdata);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end else begin
            $display("check %s = %h", name, got);
        end
    endtask

    // Wait for the sequencer to leave IDLE and come back, with cycle bounds.
    task automatic wait_seq(input string name);
        int n;
        n = 0;
        while (dut.pc == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL %s_start got timeout required pc leaving 0", name);
        end
        n = 0;
        while (dut.pc != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL %s_end got timeout required pc back at 0", name);
        end
    endtask

    task automatic do_enter(input logic [7:0] sw, input logic [31:0] e1, input logic [31:0] e0);
        exp_q.push_back('{addr: 4'd1, data: e1});
        exp_q.push_back('{addr: 4'd0, data: e0});
        Sw   = sw;
        Btn3 = 1'b1;
        wait_seq("enter");
        Btn3 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_exec(input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4);
        exp_q.push_back('{addr: 4'd2, data: e2});
        exp_q.push_back('{addr: 4'd3, data: e3});
        exp_q.push_back('{addr: 4'd4, data: e4});
        Btn2 = 1'b1;
        wait_seq("exec");
        Btn2 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Watch a full refresh cycle: select must rotate one-hot-low and each
    // digit must show the font of the matching nibble.
    task automatic check_disp(input logic [15:0] val);
        logic [7:0] got [4];
        logic [3:0] prev_sel;
        int d;
        int bad_seq;
        bad_seq = 0;
        for (int i = 0; i < 4; i++) got[i] = 8'h00;
        prev_sel = Disp_sel;
        repeat (80) begin
            @(negedge clk);
            case (Disp_sel)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = -1;
            endcase
            if (d < 0) bad_seq++;
            else got[d] = Disp;
            if (Disp_sel != prev_sel && Disp_sel != {prev_sel[2:0], prev_sel[3]}) bad_seq++;
            prev_sel = Disp_sel;
        end
        chk("disp_sel_sequence_errors", bad_seq, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("disp_digit%0d", i), {24'h0, got[i]}, {24'h0, hex_seg(val[4*i +: 4])});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int busy;

        // Reset state
        rst = 1'b1; Btn2 = 1'b0; Btn3 = 1'b0; Sw = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_pc", 32'(dut.pc), 0);
        chk("reset_trap", {31'h0, trap}, 0);
        chk("reset_data_we", {31'h0, dut.data_we}, 0);
        chk("reset_disp_sel", {28'h0, Disp_sel}, 32'h0000000E);
        chk("reset_disp", {24'h0, Disp}, 32'h000000C0);
        for (int i = 0; i < 16; i++) chk($sformatf("reset_r%0d", i), dut.regf.regf[i], 0);
        rst = 1'b0;
        check_disp(16'h0000);

        // ENTER held through reset, then EXEC
        Sw = 8'hFF; Btn3 = 1'b1; rst = 1'b1;
        exp_q.push_back('{addr: 4'd1, data: 32'h00000000});
        exp_q.push_back('{addr: 4'd0, data: 32'hFFFFFFFF});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_seq("held_enter");
        chk("held_r0", dut.regf.regf[0], 32'hFFFFFFFF);
        chk("held_r1", dut.regf.regf[1], 32'h00000000);
        Btn3 = 1'b0; Sw = 8'h01;
        do_exec(32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        chk("held_r2", dut.regf.regf[2], 32'hFFFFFFFF);
        chk("held_r3", dut.regf.regf[3], 32'h00000001);
        chk("held_r4", dut.regf.regf[4], 32'h00000000);
        chk("held_trap", {31'h0, trap}, 0);
        check_disp(16'hFFFF);

        // Signed arithmetic: 5 and -3
        do_enter(8'h05, 32'hFFFFFFFF, 32'h00000005);
        do_enter(8'hFD, 32'h00000005, 32'hFFFFFFFD);
        chk("signed_r1", dut.regf.regf[1], 32'h00000005);
        chk("signed_r0", dut.regf.regf[0], 32'hFFFFFFFD);
        do_exec(32'h00000002, 32'h00000003, 32'hFFFFFFF1);
        chk("signed_r2", dut.regf.regf[2], 32'h00000002);
        chk("signed_r3", dut.regf.regf[3], 32'h00000003);
        chk("signed_r4", dut.regf.regf[4], 32'hFFFFFFF1);
        check_disp(16'h0002);

        // Simultaneous edges: trap, no sequence, no writes
        Btn2 = 1'b1; Btn3 = 1'b1;
        busy = 0;
        repeat (8) begin
            @(negedge clk);
            if (dut.pc != 0) busy++;
        end
        chk("simul_pc_busy_cycles", busy, 0);
        chk("simul_trap", {31'h0, trap}, 1);
        Btn2 = 1'b0; Btn3 = 1'b0;
        repeat (4) @(negedge clk);
        chk("simul_r0", dut.regf.regf[0], 32'hFFFFFFFD);
        chk("simul_r1", dut.regf.regf[1], 32'h00000005);
        do_exec(32'h00000002, 32'h00000003, 32'hFFFFFFF1);
        chk("simul_trap_sticky", {31'h0, trap}, 1);

        // Busy lockout: the Btn3 edge reaches the sequencer while pc = 1
        exp_q.push_back('{addr: 4'd2, data: 32'h00000002});
        exp_q.push_back('{addr: 4'd3, data: 32'h00000003});
        exp_q.push_back('{addr: 4'd4, data: 32'hFFFFFFF1});
        Btn2 = 1'b1;
        @(negedge clk);
        Btn3 = 1'b1;
        wait_seq("lockout");
        Btn2 = 1'b0; Btn3 = 1'b0;
        repeat (8) @(negedge clk);
        chk("lockout_r0", dut.regf.regf[0], 32'hFFFFFFFD);
        chk("lockout_r1", dut.regf.regf[1], 32'h00000005);
        chk("lockout_pc", 32'(dut.pc), 0);
        chk("queue_drained", exp_q.size(), 0);

        // Reset mid-sequence at pc = 2
        exp_q.push_back('{addr: 4'd2, data: 32'h00000002});
        exp_q.push_back('{addr: 4'd3, data: 32'h00000003});
        exp_q.push_back('{addr: 4'd4, data: 32'hFFFFFFF1});
        Btn2 = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            if (dut.pc == 2) break;
            n++;
        end
        chk("midreset_reached_pc2", 32'(dut.pc), 2);
        rst = 1'b1; Btn2 = 1'b0;
        #1;
        chk("midreset_pc", 32'(dut.pc), 0);
        chk("midreset_trap", {31'h0, trap}, 0);
        chk("midreset_data_we", {31'h0, dut.data_we}, 0);
        for (int i = 0; i < 16; i++) chk($sformatf("midreset_r%0d", i), dut.regf.regf[i], 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("after_reset_pc", 32'(dut.pc), 0);
        chk("after_reset_r2", dut.regf.regf[2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
